// File: rtl/hazard_scheduler_if.sv
// Fetch/operand-fetch/write-back signal bundle for the hazard scheduler.
interface hazard_scheduler_if;
  logic       if_valid;
  logic [3:0] if_rs1;
  logic [3:0] if_rs2;
  logic       if_rs2_en;
  logic [3:0] if_rd;
  logic       if_rd_we;
  logic [1:0] stall_ctrl;
  logic       br_resolved;
  logic       br_taken;
  logic       wb_valid;
  logic [3:0] wb_addr;
  logic       issue;
  logic       if_stall;
  logic       of_bubble;
  logic       flush;
  logic [1:0] state;
  logic [7:0] stall_cycles;

  modport master (
    output if_valid, if_rs1, if_rs2, if_rs2_en, if_rd, if_rd_we,
           stall_ctrl, br_resolved, br_taken, wb_valid, wb_addr,
    input  issue, if_stall, of_bubble, flush, state, stall_cycles
  );

  modport slave (
    input  if_valid, if_rs1, if_rs2, if_rs2_en, if_rd, if_rd_we,
           stall_ctrl, br_resolved, br_taken, wb_valid, wb_addr,
    output issue, if_stall, of_bubble, flush, state, stall_cycles
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Issue scheduler between fetch and operand fetch: register scoreboard
// with write-back bypass, plus load/branch/halt stall sequencing.
//
// state  | meaning
// RUN    | normal issue, stalls only on scoreboard hazards
// LOAD   | single bubble cycle for a load-use slot
// BRANCH | hold fetch until the branch resolves, then optionally flush
// HALT   | hold forever; only reset leaves this state
module hazard_scheduler (
  input logic          clk,
  input logic          rst_n,
  hazard_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LOAD   = 2'b01,
    ST_BRANCH = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] pend_q;
  logic [15:0] pend_eff;
  logic [15:0] set_mask;
  logic        hazard;
  logic [7:0]  cnt_q;
  logic        issue_w;
  logic        stall_w;
  logic        bubble_w;
  logic        flush_w;

  // Retiring write-back is visible to the hazard check in the same cycle.
  always_comb begin
    pend_eff = pend_q;
    if (bus.wb_valid) pend_eff[bus.wb_addr] = 1'b0;
  end

  assign hazard = bus.if_valid &&
                  (pend_eff[bus.if_rs1] ||
                   (bus.if_rs2_en && pend_eff[bus.if_rs2]) ||
                   (bus.if_rd_we && pend_eff[bus.if_rd]));

  // Destination of an accepted writer becomes pending; set overrides clear.
  always_comb begin
    set_mask = '0;
    if (issue_w && bus.if_rd_we) set_mask[bus.if_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_eff | set_mask;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic; stall codes are only sampled in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        case (bus.stall_ctrl)
          2'b11:   state_d = ST_HALT;
          2'b10:   state_d = ST_BRANCH;
          2'b01:   state_d = ST_LOAD;
          default: state_d = ST_RUN;
        endcase
      end
      ST_LOAD:   state_d = ST_RUN;
      ST_BRANCH: if (bus.br_resolved) state_d = ST_RUN;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output decode; everything is forced quiet while reset is held.
  always_comb begin
    issue_w  = 1'b0;
    stall_w  = 1'b0;
    bubble_w = 1'b0;
    flush_w  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.stall_ctrl != 2'b00 || hazard) begin
            stall_w  = 1'b1;
            bubble_w = 1'b1;
          end else begin
            issue_w = bus.if_valid;
          end
        end
        ST_BRANCH: begin
          bubble_w = 1'b1;
          if (bus.br_resolved) flush_w = bus.br_taken;
          else                 stall_w = 1'b1;
        end
        default: begin
          stall_w  = 1'b1;
          bubble_w = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (stall_w && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end

  assign bus.issue        = issue_w;
  assign bus.if_stall     = stall_w;
  assign bus.of_bubble    = bubble_w;
  assign bus.flush        = flush_w;
  assign bus.state        = state_q;
  assign bus.stall_cycles = cnt_q;

endmodule
